// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Registers the winner's operands, captures the result, and acks the winner.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic [DATA_W-1:0] In1A,
  input  logic [DATA_W-1:0] In2A,
  input  logic [DATA_W-1:0] In1B,
  input  logic [DATA_W-1:0] In2B,
  input  logic [CTRL_W-1:0] CtrlA,
  input  logic [CTRL_W-1:0] CtrlB,
  output logic              AckA,
  output logic              AckB,
  output logic [DATA_W-1:0] ResultA,
  output logic [DATA_W-1:0] ResultB,
  output logic              ZeroA,
  output logic              ZeroB,
  output logic              ErrA,
  output logic              ErrB,
  output logic [1:0]        Grant,
  output logic              Busy,
  output logic [DATA_W-1:0] AluIn1,
  output logic [DATA_W-1:0] AluIn2,
  output logic [CTRL_W-1:0] AluCtrl,
  input  logic [DATA_W-1:0] AluOut,
  input  logic              AluZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // prio_q: 0 favours A, 1 favours B
  logic              prio_q, prio_d;
  logic              win_b;
  logic [1:0]        grant_d;
  logic [DATA_W-1:0] in1_d, in2_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              ack_a_d, ack_b_d;
  logic [DATA_W-1:0] res_a_d, res_b_d;
  logic              zero_a_d, zero_b_d;
  logic              err_a_d, err_b_d;
  logic [DATA_W-1:0] cap_res;
  logic              cap_zero, cap_err;

  assign Busy  = (state_q != IDLE);
  assign win_b = ReqB & (~ReqA | prio_q);

  // beq and illegal ops bypass the ALU's own outputs
  always_comb begin
    cap_res  = AluOut;
    cap_zero = AluZero;
    cap_err  = 1'b0;
    unique case (1'b1)
      (AluCtrl > CTRL_W'(7)): begin
        cap_res  = '0;
        cap_zero = 1'b1;
        cap_err  = 1'b1;
      end
      (AluCtrl == CTRL_W'(6)): begin
        cap_res  = '0;
        cap_zero = (AluIn1 == AluIn2);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    grant_d  = Grant;
    in1_d    = AluIn1;
    in2_d    = AluIn2;
    ctrl_d   = AluCtrl;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    res_a_d  = ResultA;
    res_b_d  = ResultB;
    zero_a_d = ZeroA;
    zero_b_d = ZeroB;
    err_a_d  = ErrA;
    err_b_d  = ErrB;
    unique case (state_q)
      IDLE: begin
        if (ReqA | ReqB) begin
          state_d = EXEC;
          grant_d = win_b ? 2'b10 : 2'b01;
          in1_d   = win_b ? In1B : In1A;
          in2_d   = win_b ? In2B : In2A;
          ctrl_d  = win_b ? CtrlB : CtrlA;
          if (ReqA & ReqB) prio_d = ~win_b;
        end
      end
      EXEC: begin
        state_d = DONE;
        if (Grant[1]) begin
          ack_b_d  = 1'b1;
          res_b_d  = cap_res;
          zero_b_d = cap_zero;
          err_b_d  = cap_err;
        end else begin
          ack_a_d  = 1'b1;
          res_a_d  = cap_res;
          zero_a_d = cap_zero;
          err_a_d  = cap_err;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      Grant   <= 2'b00;
      AluIn1  <= '0;
      AluIn2  <= '0;
      AluCtrl <= '0;
      AckA    <= 1'b0;
      AckB    <= 1'b0;
      ResultA <= '0;
      ResultB <= '0;
      ZeroA   <= 1'b0;
      ZeroB   <= 1'b0;
      ErrA    <= 1'b0;
      ErrB    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      Grant   <= grant_d;
      AluIn1  <= in1_d;
      AluIn2  <= in2_d;
      AluCtrl <= ctrl_d;
      AckA    <= ack_a_d;
      AckB    <= ack_b_d;
      ResultA <= res_a_d;
      ResultB <= res_b_d;
      ZeroA   <= zero_a_d;
      ZeroB   <= zero_b_d;
      ErrA    <= err_a_d;
      ErrB    <= err_b_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU.
// Expected results are queued per port at request time.
module tb_alu_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqA = 1'b0, ReqB = 1'b0;
  logic [31:0] In1A = '0, In2A = '0;
  logic [31:0] In1B = '0, In2B = '0;
  logic [3:0]  CtrlA = '0, CtrlB = '0;
  logic        AckA, AckB;
  logic [31:0] ResultA, ResultB;
  logic        ZeroA, ZeroB, ErrA, ErrB;
  logic [1:0]  Grant;
  logic        Busy;
  logic [31:0] AluIn1, AluIn2;
  logic [3:0]  AluCtrl;
  logic [31:0] AluOut;
  logic        AluZero;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqA(ReqA), .ReqB(ReqB),
    .In1A(In1A), .In2A(In2A),
    .In1B(In1B), .In2B(In2B),
    .CtrlA(CtrlA), .CtrlB(CtrlB),
    .AckA(AckA), .AckB(AckB),
    .ResultA(ResultA), .ResultB(ResultB),
    .ZeroA(ZeroA), .ZeroB(ZeroB),
    .ErrA(ErrA), .ErrB(ErrB),
    .Grant(Grant), .Busy(Busy),
    .AluIn1(AluIn1), .AluIn2(AluIn2),
    .AluCtrl(AluCtrl),
    .AluOut(AluOut), .AluZero(AluZero)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // ALU model; beq/illegal outputs are deliberately misleading
  always_comb begin
    AluOut  = '0;
    AluZero = 1'b0;
    case (AluCtrl)
      4'd0, 4'd1, 4'd2: AluOut = AluIn1 + AluIn2;
      4'd3: AluOut = AluIn1 & AluIn2;
      4'd4: AluOut = ~(AluIn1 | AluIn2);
      4'd5: AluOut = AluIn1 << AluIn2[4:0];
      4'd7: AluOut = (AluIn1 < AluIn2) ? 32'd1 : 32'd0;
      default: AluOut = 32'hDEAD_BEEF;
    endcase
    AluZero = (AluOut == 32'd0);
    if (AluCtrl == 4'd6) AluZero = (AluIn1 != AluIn2);
  end

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [3:0] c);
    exp_t r;
    r.e = 1'b0;
    case (c)
      4'd0, 4'd1, 4'd2: r.res = a + b;
      4'd3: r.res = a & b;
      4'd4: r.res = ~(a | b);
      4'd5: r.res = a << b[4:0];
      4'd6: r.res = 32'd0;
      4'd7: r.res = (a < b) ? 32'd1 : 32'd0;
      default: begin
        r.res = 32'd0;
        r.e   = 1'b1;
      end
    endcase
    if (c == 4'd6) r.z = (a == b);
    else r.z = (r.res == 32'd0);
    return r;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge Clk) begin
    exp_t e;
    if (AckA | AckB) check("one_ack", 32'(AckA & AckB), 32'd0);
    if (AckA) begin
      check("gntA", 32'(Grant), 32'd1);
      if (qa.size() == 0) check("unexpA", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        check("resA", ResultA, e.res);
        check("zeroA", 32'(ZeroA), 32'(e.z));
        check("errA", 32'(ErrA), 32'(e.e));
      end
    end
    if (AckB) begin
      check("gntB", 32'(Grant), 32'd2);
      if (qb.size() == 0) check("unexpB", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        check("resB", ResultB, e.res);
        check("zeroB", 32'(ZeroB), 32'(e.z));
        check("errB", 32'(ErrB), 32'(e.e));
      end
    end
  end

  task automatic wait_ack(output logic wb, output int t,
                          output logic ok);
    ok = 1'b0;
    wb = 1'b0;
    t  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (AckA | AckB) begin
        ok = 1'b1;
        wb = AckB;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic run_op(input logic pb, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] c);
    logic wb, ok;
    int t, t0;
    @(posedge Clk);
    #1;
    if (pb) begin
      In1B = a; In2B = b; CtrlB = c; ReqB = 1'b1;
      qb.push_back(model(a, b, c));
    end else begin
      In1A = a; In2A = b; CtrlA = c; ReqA = 1'b1;
      qa.push_back(model(a, b, c));
    end
    t0 = cyc;
    wait_ack(wb, t, ok);
    check("ack_seen", 32'(ok), 32'd1);
    check("ack_port", 32'(wb), 32'(pb));
    check("latency", 32'(t - t0), 32'd2);
    @(posedge Clk);
    #1;
    ReqA = 1'b0;
    ReqB = 1'b0;
  endtask

  initial begin
    logic wb, ok;
    int t, tp;
    // contention operands presented from reset
    In1A = 32'h0000_F0F0; In2A = 32'h0000_FF00; CtrlA = 4'd3;
    In1B = 32'h0000_0F0F; In2B = 32'h0000_F0F0; CtrlB = 4'd3;
    ReqA = 1'b1; ReqB = 1'b1;
    #12;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_grant", 32'(Grant), 32'd0);
    check("rst_ack", 32'({AckA, AckB}), 32'd0);
    check("rst_res", ResultA | ResultB, 32'd0);
    check("rst_flags", 32'({ZeroA, ZeroB, ErrA, ErrB}), 32'd0);
    check("rst_alu", AluIn1 | AluIn2 | 32'(AluCtrl), 32'd0);

    for (int i = 0; i < 2; i++) begin
      qa.push_back(model(In1A, In2A, CtrlA));
      qb.push_back(model(In1B, In2B, CtrlB));
    end
    @(negedge Clk);
    Rst = 1'b0;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(wb, t, ok);
      check("rr_seen", 32'(ok), 32'd1);
      check("rr_order", 32'(wb), 32'(i % 2));
      if (i > 0) check("rr_space", 32'(t - tp), 32'd3);
      tp = t;
    end
    @(posedge Clk);
    #1;
    ReqA = 1'b0;
    ReqB = 1'b0;

    run_op(1'b0, 32'd5, 32'd7, 4'd0);
    run_op(1'b1, 32'h1234, 32'h1234, 4'd6);
    run_op(1'b1, 32'h1234, 32'h1235, 4'd6);
    check("holdA", ResultA, 32'd12);
    run_op(1'b0, 32'd5, 32'd7, 4'hC);
    run_op(1'b0, 32'd2, 32'd3, 4'd5);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd7);
    run_op(1'b1, 32'd0, 32'd0, 4'd4);
    run_op(1'b0, 32'd1, 32'd2, 4'd7);

    // Prio is A here; A wins, Prio moves to B, then reset in EXEC
    @(posedge Clk);
    #1;
    In1A = 32'd3; In2A = 32'd4; CtrlA = 4'd0;
    In1B = 32'd9; In2B = 32'd9; CtrlB = 4'd3;
    ReqA = 1'b1; ReqB = 1'b1;
    @(posedge Clk);
    #2;
    check("exec_busy", 32'(Busy), 32'd1);
    check("exec_alu", AluIn1, 32'd3);
    Rst = 1'b1;
    #1;
    check("mrst_busy", 32'(Busy), 32'd0);
    check("mrst_grant", 32'(Grant), 32'd0);
    check("mrst_res", ResultA | ResultB, 32'd0);
    check("mrst_flags", 32'({AckA, AckB, ZeroA, ZeroB, ErrA, ErrB}), 32'd0);
    check("mrst_alu", AluIn1 | AluIn2 | 32'(AluCtrl), 32'd0);
    qa.push_back(model(32'd3, 32'd4, 4'd0));
    @(negedge Clk);
    Rst = 1'b0;
    wait_ack(wb, t, ok);
    check("post_seen", 32'(ok), 32'd1);
    check("post_prio", 32'(wb), 32'd0);
    @(posedge Clk);
    #1;
    ReqA = 1'b0;
    ReqB = 1'b0;

    repeat (4) @(posedge Clk);
    #1;
    check("idle_busy", 32'(Busy), 32'd0);
    check("qa_left", 32'(qa.size()), 32'd0);
    check("qb_left", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
